// File: rtl/tlb_pkg.sv
// Shared CPU header constants and types for the TLB: entry count, index
// width, field widths and the packed entry record.
package tlb_pkg;

  localparam int TLBNUM    = 16;
  localparam int TLB_IDX_W = 4;
  localparam int VPN2_W    = 19;
  localparam int ASID_W    = 8;
  localparam int PFN_W     = 20;
  localparam int CACHE_W   = 3;

  // One TLB entry: tag (vpn2/asid/g) plus even and odd half-page fields.
  typedef struct packed {
    logic [VPN2_W-1:0]  vpn2;
    logic [ASID_W-1:0]  asid;
    logic               g;
    logic [PFN_W-1:0]   pfn0;
    logic [CACHE_W-1:0] c0;
    logic               d0;
    logic               v0;
    logic [PFN_W-1:0]   pfn1;
    logic [CACHE_W-1:0] c1;
    logic               d1;
    logic               v1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_search.sv
// One combinational search port: per-entry tag compare, lowest-index
// priority select and even/odd half-page mux. Outputs are all zero on a miss.
module tlb_search
  import tlb_pkg::*;
(
  input  tlb_entry_t [TLBNUM-1:0] entries,
  input  logic [VPN2_W-1:0]       vpn2,
  input  logic                    odd_page,
  input  logic [ASID_W-1:0]       asid,
  output logic                    found,
  output logic [TLB_IDX_W-1:0]    index,
  output logic [PFN_W-1:0]        pfn,
  output logic [CACHE_W-1:0]      c,
  output logic                    d,
  output logic                    v
);

  logic [TLBNUM-1:0] match;
  tlb_entry_t        sel;

  // Tag compare per entry; the global bit bypasses the ASID check, V is ignored.
  always_comb begin
    match = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match[i] = (entries[i].vpn2 == vpn2) &&
                 (entries[i].g || (entries[i].asid == asid));
    end
  end

  // Priority encode: scanning downward lets the lowest matching index win.
  always_comb begin
    found = 1'b0;
    index = '0;
    sel   = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) begin
        found = 1'b1;
        index = TLB_IDX_W'(i);
        sel   = entries[i];
      end
    end
  end

  // Half-page select; forced to zero on a miss.
  always_comb begin
    pfn = '0;
    c   = '0;
    d   = 1'b0;
    v   = 1'b0;
    if (found) begin
      if (odd_page) begin
        pfn = sel.pfn1;
        c   = sel.c1;
        d   = sel.d1;
        v   = sel.v1;
      end else begin
        pfn = sel.pfn0;
        c   = sel.c0;
        d   = sel.d0;
        v   = sel.v0;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// 16-entry fully associative TLB: two independent combinational search
// ports (0 = fetch, 1 = data/TLBP), one write port (TLBWI) and one
// combinational read port (TLBR). Writes land at the clock edge, so reads
// and searches in the write cycle observe the old contents.
module tlb
  import tlb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic [VPN2_W-1:0]    s0_vpn2,
  input  logic                 s0_odd_page,
  input  logic [ASID_W-1:0]    s0_asid,
  output logic                 s0_found,
  output logic [TLB_IDX_W-1:0] s0_index,
  output logic [PFN_W-1:0]     s0_pfn,
  output logic [CACHE_W-1:0]   s0_c,
  output logic                 s0_d,
  output logic                 s0_v,

  input  logic [VPN2_W-1:0]    s1_vpn2,
  input  logic                 s1_odd_page,
  input  logic [ASID_W-1:0]    s1_asid,
  output logic                 s1_found,
  output logic [TLB_IDX_W-1:0] s1_index,
  output logic [PFN_W-1:0]     s1_pfn,
  output logic [CACHE_W-1:0]   s1_c,
  output logic                 s1_d,
  output logic                 s1_v,

  input  logic                 we,
  input  logic [TLB_IDX_W-1:0] w_index,
  input  logic [VPN2_W-1:0]    w_vpn2,
  input  logic [ASID_W-1:0]    w_asid,
  input  logic                 w_g,
  input  logic [PFN_W-1:0]     w_pfn0,
  input  logic [CACHE_W-1:0]   w_c0,
  input  logic                 w_d0,
  input  logic                 w_v0,
  input  logic [PFN_W-1:0]     w_pfn1,
  input  logic [CACHE_W-1:0]   w_c1,
  input  logic                 w_d1,
  input  logic                 w_v1,

  input  logic [TLB_IDX_W-1:0] r_index,
  output logic [VPN2_W-1:0]    r_vpn2,
  output logic [ASID_W-1:0]    r_asid,
  output logic                 r_g,
  output logic [PFN_W-1:0]     r_pfn0,
  output logic [CACHE_W-1:0]   r_c0,
  output logic                 r_d0,
  output logic                 r_v0,
  output logic [PFN_W-1:0]     r_pfn1,
  output logic [CACHE_W-1:0]   r_c1,
  output logic                 r_d1,
  output logic                 r_v1
);

  tlb_entry_t [TLBNUM-1:0] entries;
  tlb_entry_t              w_entry;
  tlb_entry_t              r_entry;

  // Gather the write-port fields into one entry record.
  always_comb begin
    w_entry      = '0;
    w_entry.vpn2 = w_vpn2;
    w_entry.asid = w_asid;
    w_entry.g    = w_g;
    w_entry.pfn0 = w_pfn0;
    w_entry.c0   = w_c0;
    w_entry.d0   = w_d0;
    w_entry.v0   = w_v0;
    w_entry.pfn1 = w_pfn1;
    w_entry.c1   = w_c1;
    w_entry.d1   = w_d1;
    w_entry.v1   = w_v1;
  end

  // Entry storage: reset clears everything and overrides a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '0;
    end else if (we) begin
      entries[w_index] <= w_entry;
    end
  end

  // Read port: straight from storage, no write bypass.
  always_comb begin
    r_entry = entries[r_index];
    r_vpn2  = r_entry.vpn2;
    r_asid  = r_entry.asid;
    r_g     = r_entry.g;
    r_pfn0  = r_entry.pfn0;
    r_c0    = r_entry.c0;
    r_d0    = r_entry.d0;
    r_v0    = r_entry.v0;
    r_pfn1  = r_entry.pfn1;
    r_c1    = r_entry.c1;
    r_d1    = r_entry.d1;
    r_v1    = r_entry.v1;
  end

  tlb_search u_search0 (
    .entries  (entries),
    .vpn2     (s0_vpn2),
    .odd_page (s0_odd_page),
    .asid     (s0_asid),
    .found    (s0_found),
    .index    (s0_index),
    .pfn      (s0_pfn),
    .c        (s0_c),
    .d        (s0_d),
    .v        (s0_v)
  );

  tlb_search u_search1 (
    .entries  (entries),
    .vpn2     (s1_vpn2),
    .odd_page (s1_odd_page),
    .asid     (s1_asid),
    .found    (s1_found),
    .index    (s1_index),
    .pfn      (s1_pfn),
    .c        (s1_c),
    .d        (s1_d),
    .v        (s1_v)
  );

endmodule

// File: tb/tb_tlb.sv
// Bench for tlb: directed writes, a table of search vectors applied to both
// ports, hand-written same-cycle/reset corners, and randomized traffic checked
// against an array-based reference of the TLB contents.
module tb_tlb;

  localparam int SR_W = 1 + 4 + 20 + 3 + 1 + 1;
  localparam int ENT_W = 19 + 8 + 1 + 20 + 3 + 1 + 1 + 20 + 3 + 1 + 1;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } ent_t;

  typedef struct {
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } vec_t;

  logic clk, rst;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        we;
  logic [3:0]  w_index, r_index;
  ent_t        w_ent;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;

  int tests = 0;
  int fails = 0;
  ent_t model [16];
  logic [SR_W-1:0] exp_q [$];

  tlb dut (
    .clk(clk), .rst(rst),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index),
    .w_vpn2(w_ent.vpn2), .w_asid(w_ent.asid), .w_g(w_ent.g),
    .w_pfn0(w_ent.pfn0), .w_c0(w_ent.c0), .w_d0(w_ent.d0), .w_v0(w_ent.v0),
    .w_pfn1(w_ent.pfn1), .w_c1(w_ent.c1), .w_d1(w_ent.d1), .w_v1(w_ent.v1),
    .r_index(r_index),
    .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SR_W-1:0] pack_sr(logic f, logic [3:0] i, logic [19:0] p,
                                              logic [2:0] c, logic d, logic v);
    return {f, i, p, c, d, v};
  endfunction

  // Reference search: first entry in index order satisfying the match rule.
  function automatic logic [SR_W-1:0] ref_search(logic [18:0] vpn2, logic odd, logic [7:0] asid);
    for (int i = 0; i < 16; i++) begin
      if (model[i].vpn2 == vpn2 && (model[i].g || model[i].asid == asid)) begin
        if (odd) return pack_sr(1'b1, 4'(i), model[i].pfn1, model[i].c1, model[i].d1, model[i].v1);
        else     return pack_sr(1'b1, 4'(i), model[i].pfn0, model[i].c0, model[i].d0, model[i].v0);
      end
    end
    return '0;
  endfunction

  task automatic chk(input string name, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SR_W-1:0] dut_sr(int port);
    if (port == 0) return pack_sr(s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v);
    return pack_sr(s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v);
  endfunction

  function automatic ent_t dut_rd();
    return '{r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
  endfunction

  // Scoreboard: compare the oldest expected search result with a port.
  task automatic sb_check(input string name, input int port);
    logic [SR_W-1:0] e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, ENT_W'(dut_sr(port)), ENT_W'(e));
    end
  endtask

  task automatic set_search(input int port, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    if (port == 0) begin s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid; end
    else           begin s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid; end
  endtask

  // Driver: one-cycle TLBWI, model updated once the edge has passed.
  task automatic write_entry(input int idx, input ent_t e);
    @(negedge clk);
    we = 1'b1; w_index = 4'(idx); w_ent = e;
    @(posedge clk);
    #1;
    we = 1'b0;
    model[idx] = e;
  endtask

  function automatic ent_t mk(logic [18:0] vpn2, logic [7:0] asid, logic g,
                              logic [19:0] pfn0, logic [2:0] c0, logic d0, logic v0,
                              logic [19:0] pfn1, logic [2:0] c1, logic d1, logic v1);
    return '{vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
  endfunction

  vec_t vecs [9];
  ent_t re;

  initial begin
    rst = 1'b1; we = 1'b0; w_index = '0; w_ent = '0; r_index = '0;
    set_search(0, '0, 1'b0, '0);
    set_search(1, '0, 1'b0, '0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state: all-zero array matches vpn2=0/asid=0 at index 0.
    set_search(0, 19'h0, 1'b0, 8'h00);
    set_search(1, 19'h00001, 1'b0, 8'h00);
    #1;
    exp_q.push_back(pack_sr(1'b1, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0));
    sb_check("reset_s0_zero", 0);
    exp_q.push_back('0);
    sb_check("reset_s1_miss", 1);
    chk("reset_read0", ENT_W'(dut_rd()), '0);

    // Directed writes.
    write_entry(5, mk(19'h12345, 8'h0A, 1'b0, 20'h00111, 3'd0, 1'b0, 1'b1, 20'h00222, 3'd3, 1'b1, 1'b1));
    write_entry(3, mk(19'h7FFFF, 8'h01, 1'b1, 20'hABCDE, 3'd0, 1'b0, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0));
    write_entry(9, mk(19'h00400, 8'h05, 1'b0, 20'h99999, 3'd1, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    write_entry(2, mk(19'h00400, 8'h05, 1'b0, 20'h22222, 3'd2, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));

    // Search vectors: {vpn2, odd, asid, found, index, pfn, c, d, v}
    vecs[0] = '{19'h12345, 1'b1, 8'h0A, 1'b1, 4'd5, 20'h00222, 3'd3, 1'b1, 1'b1};
    vecs[1] = '{19'h12345, 1'b1, 8'h0B, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{19'h12345, 1'b0, 8'h0A, 1'b1, 4'd5, 20'h00111, 3'd0, 1'b0, 1'b1};
    vecs[3] = '{19'h7FFFF, 1'b0, 8'hFF, 1'b1, 4'd3, 20'hABCDE, 3'd0, 1'b0, 1'b0};
    vecs[4] = '{19'h7FFFF, 1'b1, 8'h22, 1'b1, 4'd3, 20'h00000, 3'd0, 1'b0, 1'b0};
    vecs[5] = '{19'h00400, 1'b0, 8'h05, 1'b1, 4'd2, 20'h22222, 3'd2, 1'b1, 1'b1};
    vecs[6] = '{19'h00400, 1'b0, 8'h06, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};
    vecs[7] = '{19'h00000, 1'b0, 8'h00, 1'b1, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};
    vecs[8] = '{19'h00000, 1'b1, 8'h01, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};

    // Both ports in the same cycle, each on a different vector.
    for (int i = 0; i < 9; i++) begin
      int j;
      j = (i + 1) % 9;
      @(negedge clk);
      set_search(0, vecs[i].vpn2, vecs[i].odd, vecs[i].asid);
      set_search(1, vecs[j].vpn2, vecs[j].odd, vecs[j].asid);
      #1;
      exp_q.push_back(pack_sr(vecs[i].found, vecs[i].index, vecs[i].pfn, vecs[i].c, vecs[i].d, vecs[i].v));
      sb_check($sformatf("vec%0d_s0", i), 0);
      exp_q.push_back(pack_sr(vecs[j].found, vecs[j].index, vecs[j].pfn, vecs[j].c, vecs[j].d, vecs[j].v));
      sb_check($sformatf("vec%0d_s1", j), 1);
    end

    // Read back entry 5 exactly as written.
    r_index = 4'd5;
    #1;
    chk("read5", ENT_W'(dut_rd()),
        ENT_W'(mk(19'h12345, 8'h0A, 1'b0, 20'h00111, 3'd0, 1'b0, 1'b1, 20'h00222, 3'd3, 1'b1, 1'b1)));

    // Write to index 7 while s1 searches it and read port looks at it.
    @(negedge clk);
    we = 1'b1; w_index = 4'd7;
    w_ent = mk(19'h55555, 8'h07, 1'b0, 20'h77777, 3'd5, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    set_search(1, 19'h55555, 1'b0, 8'h07);
    r_index = 4'd7;
    #1;
    exp_q.push_back('0);
    sb_check("wr7_same_cycle_s1", 1);
    chk("wr7_same_cycle_read", ENT_W'(dut_rd()), '0);
    @(posedge clk);
    #1;
    we = 1'b0;
    model[7] = w_ent;
    #1;
    exp_q.push_back(pack_sr(1'b1, 4'd7, 20'h77777, 3'd5, 1'b0, 1'b1));
    sb_check("wr7_next_cycle_s1", 1);

    // Randomized traffic against the reference array.
    for (int n = 0; n < 300; n++) begin
      ent_t e;
      logic wr;
      int wi;
      @(negedge clk);
      e = mk(19'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      wr = ($urandom_range(0, 1) == 1);
      wi = $urandom_range(0, 15);
      we = wr; w_index = 4'(wi); w_ent = e;
      set_search(0, 19'($urandom_range(0, 3)), 1'($urandom), 8'($urandom_range(0, 3)));
      set_search(1, 19'($urandom_range(0, 4)), 1'($urandom), 8'($urandom_range(0, 3)));
      r_index = 4'($urandom_range(0, 15));
      #1;
      exp_q.push_back(ref_search(s0_vpn2, s0_odd_page, s0_asid));
      sb_check("rand_s0", 0);
      exp_q.push_back(ref_search(s1_vpn2, s1_odd_page, s1_asid));
      sb_check("rand_s1", 1);
      re = model[r_index];
      chk("rand_read", ENT_W'(dut_rd()), ENT_W'(re));
      @(posedge clk);
      #1;
      we = 1'b0;
      if (wr) model[wi] = e;
    end

    // Reset wins over a simultaneous write.
    write_entry(4, mk(19'h01234, 8'h44, 1'b1, 20'h44444, 3'd4, 1'b1, 1'b1, 20'h44445, 3'd4, 1'b1, 1'b1));
    @(negedge clk);
    rst = 1'b1; we = 1'b1; w_index = 4'd4;
    w_ent = mk(19'h04444, 8'h44, 1'b1, 20'hFFFFF, 3'd7, 1'b1, 1'b1, 20'hFFFFF, 3'd7, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    r_index = 4'd4;
    set_search(0, 19'h04444, 1'b0, 8'h44);
    set_search(1, 19'h0, 1'b1, 8'h00);
    #1;
    chk("rst_we_read4", ENT_W'(dut_rd()), '0);
    exp_q.push_back('0);
    sb_check("rst_we_s0_miss", 0);
    exp_q.push_back(pack_sr(1'b1, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0));
    sb_check("rst_we_s1_zero", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
